ext_pipe_stage: RTL and testbench
=================================

Name: ext_pipe_stage

Overview:
- Registered, parametrised immediate/shift-amount extension stage for the pipelined MIPS datapath. Sits between decode and execute.
- Turns a 16-bit immediate or 5-bit shamt into a DATA_W operand under a per-instruction mode, carrying a tag alongside.
- Valid/ready handshake on both sides with a 2-entry skid buffer, synchronous flush, and a saturating transfer counter.

Parameters:
DATA_W, 32, operand width; legal range >= IMM_W+2
IMM_W, 16, immediate width
SHAMT_W, 5, shift-amount width
TAG_W, 5, pass-through tag width (destination register index)
CNT_W, 16, width of the transfer counter

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
flush  in  1  synchronous pipeline flush
in_valid  in  1  input beat valid
in_ready  out  1  stage can accept a beat
in_mode  in  3  extension mode (encoding below)
in_imm  in  IMM_W  immediate field
in_shamt  in  SHAMT_W  shift-amount field
in_tag  in  TAG_W  tag carried with the beat
out_valid  out  1  output beat valid
out_ready  in  1  downstream accepts
out_data  out  DATA_W  extended operand
out_tag  out  TAG_W  tag of the output beat
out_err  out  1  beat used a reserved mode
ext_count  out  CNT_W  completed output transfers, saturating

Behaviour:
- Modes (combinational, computed on the input side):
  - 0 SEXT: imm sign-extended.
  - 1 ZEXT: imm zero-extended.
  - 2 LUI: imm placed in bits [IMM_W+15:16], low 16 bits zero; when DATA_W = 32 this is the upper half. Generally result = zext(imm) << 16, truncated to DATA_W.
  - 3 SHZ: shamt zero-extended.
  - 4 SHS: shamt sign-extended from bit SHAMT_W-1. Legacy single-cycle compatibility mode.
  - 5 BOFF: sext(imm) << 2.
  - 6, 7: reserved. out_data = 0 and out_err = 1.
- Storage: main register (drives outputs) plus a skid register. Each holds {data, tag, err, valid}.
- in_ready = !skid_valid. It is driven from a register, never combinationally from out_ready.
- Input accept = in_valid & in_ready & !flush. Output transfer = out_valid & out_ready.
- Per-cycle update, in priority order:
  - flush: both valids clear; the input beat is dropped; ext_count is unchanged even if out_ready is high.
  - Main empty or transferring: main loads the skid entry if it is valid (skid then clears, or loads the input if an accept also occurs). Otherwise main loads the accepted input, or goes invalid if there is none.
  - Main full and not transferring: an accepted input goes to the skid register.
- Latency: one cycle from accept to out_valid when no stall is present. Throughput is 1 beat/cycle with out_ready held high.
- Order is strictly FIFO. A beat is never duplicated or dropped, except on flush.
- Data/tag/err registers load only when their entry is written; they hold otherwise. Invalid entries hold stale data.
- ext_count increments on each output transfer and saturates at all-ones (no wrap). Flush does not clear it; only reset does.
- Reset values: out_valid 0, out_data 0, out_tag 0, out_err 0, ext_count 0, skid_valid 0, in_ready 1.
  - Beats presented while rst_n is low are ignored.
  - Reset asserted mid-operation discards all held beats immediately (asynchronous).

Decomposition:
- Package ext_pkg holds:
  - mode localparams EXT_SEXT=0, EXT_ZEXT=1, EXT_LUI=2, EXT_SHZ=3, EXT_SHS=4, EXT_BOFF=5;
  - mode width 3;
  - an is_reserved function.
- Sub-module ext_core: the purely combinational (mode, imm, shamt) -> (data, err) function, parametrised on DATA_W/IMM_W/SHAMT_W.
- ext_pipe_stage instantiates ext_core and implements the skid buffer, flush, and counter.

Test Plan (DATA_W=32):
- Modes with out_ready=1:
  - SEXT 0x8000 -> 0xFFFF8000
  - ZEXT 0x8000 -> 0x00008000
  - LUI 0x1234 -> 0x12340000
  - SHZ 0x13 -> 0x00000013
  - SHS 0x13 -> 0xFFFFFFF3
  - BOFF 0xFFFF -> 0xFFFFFFFC
  - mode 7 -> 0x00000000 with out_err=1
  - Each result appears 1 cycle after accept.
- Backpressure: out_ready=0, offer tags 1, 2, 3 back-to-back.
  - Tags 1 and 2 are accepted; in_ready falls the cycle after tag 2; tag 3 is held.
  - Raise out_ready: outputs appear in order 1, 2, 3, one per cycle; ext_count goes to 3.
- Flush with both entries full and in_valid=1: the next cycle has out_valid=0 and in_ready=1, ext_count is unchanged, and the offered beat never emerges.
- Streaming: 100 random beats with in_valid and out_ready both held at 1. Expect 100 in-order outputs, no bubbles after the first, and ext_count=100.
- Reset: drop rst_n for half a cycle while 2 beats are held. out_valid goes to 0 immediately and ext_count=0; after release in_ready=1 and no old beat emerges.
- Saturation: with CNT_W=4, perform 20 transfers; ext_count stops at 0xF.

Source files
------------

// File: rtl/ext_pkg.sv
// Mode encodings and helpers shared by the immediate/shift-amount extension stage.
package ext_pkg;

  localparam int MODE_W = 3;

  localparam logic [MODE_W-1:0] EXT_SEXT = 3'd0;
  localparam logic [MODE_W-1:0] EXT_ZEXT = 3'd1;
  localparam logic [MODE_W-1:0] EXT_LUI  = 3'd2;
  localparam logic [MODE_W-1:0] EXT_SHZ  = 3'd3;
  localparam logic [MODE_W-1:0] EXT_SHS  = 3'd4;
  localparam logic [MODE_W-1:0] EXT_BOFF = 3'd5;

  function automatic logic is_reserved(input logic [MODE_W-1:0] mode);
    return mode > EXT_BOFF;
  endfunction

endpackage

// File: rtl/ext_core.sv
// Combinational extension function: (mode, imm, shamt) -> (operand, reserved-mode error).
module ext_core
  import ext_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int IMM_W   = 16,
  parameter int SHAMT_W = 5
) (
  input  logic [MODE_W-1:0]  mode_i,
  input  logic [IMM_W-1:0]   imm_i,
  input  logic [SHAMT_W-1:0] shamt_i,
  output logic [DATA_W-1:0]  data_o,
  output logic               err_o
);

  logic [DATA_W-1:0] immSext;
  logic [DATA_W-1:0] immZext;
  logic [DATA_W-1:0] shamtZext;
  logic [DATA_W-1:0] shamtSext;

  assign immSext   = {{(DATA_W-IMM_W){imm_i[IMM_W-1]}}, imm_i};
  assign immZext   = {{(DATA_W-IMM_W){1'b0}}, imm_i};
  assign shamtZext = {{(DATA_W-SHAMT_W){1'b0}}, shamt_i};
  assign shamtSext = {{(DATA_W-SHAMT_W){shamt_i[SHAMT_W-1]}}, shamt_i};

  // LUI always shifts by 16 regardless of IMM_W; bits beyond DATA_W are dropped.
  always_comb begin
    data_o = '0;
    err_o  = is_reserved(mode_i);
    case (mode_i)
      EXT_SEXT: data_o = immSext;
      EXT_ZEXT: data_o = immZext;
      EXT_LUI:  data_o = immZext << 16;
      EXT_SHZ:  data_o = shamtZext;
      EXT_SHS:  data_o = shamtSext;
      EXT_BOFF: data_o = immSext << 2;
      default:  data_o = '0;
    endcase
  end

endmodule

// File: rtl/ext_pipe_stage.sv
// Registered extension stage between decode and execute: 2-entry skid buffer,
// synchronous flush and a saturating count of completed output transfers.
module ext_pipe_stage
  import ext_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int IMM_W   = 16,
  parameter int SHAMT_W = 5,
  parameter int TAG_W   = 5,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [MODE_W-1:0]  in_mode,
  input  logic [IMM_W-1:0]   in_imm,
  input  logic [SHAMT_W-1:0] in_shamt,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DATA_W-1:0]  out_data,
  output logic [TAG_W-1:0]   out_tag,
  output logic               out_err,
  output logic [CNT_W-1:0]   ext_count
);

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [TAG_W-1:0]  tag;
    logic              err;
  } entry_t;

  entry_t            inEntry;
  entry_t            main_q, main_d;
  entry_t            skid_q, skid_d;
  logic              mainValid_q, mainValid_d;
  logic              skidValid_q, skidValid_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [DATA_W-1:0] extData;
  logic              extErr;
  logic              accept;
  logic              xfer;

  ext_core #(
    .DATA_W  (DATA_W),
    .IMM_W   (IMM_W),
    .SHAMT_W (SHAMT_W)
  ) u_core (
    .mode_i  (in_mode),
    .imm_i   (in_imm),
    .shamt_i (in_shamt),
    .data_o  (extData),
    .err_o   (extErr)
  );

  assign inEntry  = '{data: extData, tag: in_tag, err: extErr};
  assign in_ready = ~skidValid_q;
  assign accept   = in_valid & in_ready & ~flush;
  assign xfer     = mainValid_q & out_ready;

  // The skid entry is always older than any new input, so it refills main first.
  always_comb begin
    main_d      = main_q;
    skid_d      = skid_q;
    mainValid_d = mainValid_q;
    skidValid_d = skidValid_q;
    if (flush) begin
      mainValid_d = 1'b0;
      skidValid_d = 1'b0;
    end else if (!mainValid_q || xfer) begin
      if (skidValid_q) begin
        main_d      = skid_q;
        mainValid_d = 1'b1;
        skidValid_d = accept;
        if (accept) skid_d = inEntry;
      end else begin
        mainValid_d = accept;
        if (accept) main_d = inEntry;
      end
    end else if (accept) begin
      skid_d      = inEntry;
      skidValid_d = 1'b1;
    end
  end

  always_comb begin
    count_d = count_q;
    if (xfer && !flush && (count_q != '1)) count_d = count_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_q      <= '0;
      skid_q      <= '0;
      mainValid_q <= 1'b0;
      skidValid_q <= 1'b0;
      count_q     <= '0;
    end else begin
      main_q      <= main_d;
      skid_q      <= skid_d;
      mainValid_q <= mainValid_d;
      skidValid_q <= skidValid_d;
      count_q     <= count_d;
    end
  end

  assign out_valid = mainValid_q;
  assign out_data  = main_q.data;
  assign out_tag   = main_q.tag;
  assign out_err   = main_q.err;
  assign ext_count = count_q;

endmodule

// File: tb/tb_ext_pipe_stage.sv
// Directed bench for ext_pipe_stage: mode table, backpressure, flush, streaming,
// asynchronous reset and counter saturation (second instance with a 4-bit counter).
module tb_ext_pipe_stage;
  import ext_pkg::*;

  localparam int DATA_W    = 32;
  localparam int IMM_W     = 16;
  localparam int SHAMT_W   = 5;
  localparam int TAG_W     = 5;
  localparam int CNT_W     = 16;
  localparam int SAT_CNT_W = 4;
  localparam int NV        = 8;
  localparam int NSTREAM   = 100;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               flush;
  logic               in_valid;
  logic               in_ready;
  logic [MODE_W-1:0]  in_mode;
  logic [IMM_W-1:0]   in_imm;
  logic [SHAMT_W-1:0] in_shamt;
  logic [TAG_W-1:0]   in_tag;
  logic               out_valid;
  logic               out_ready;
  logic [DATA_W-1:0]  out_data;
  logic [TAG_W-1:0]   out_tag;
  logic               out_err;
  logic [CNT_W-1:0]   ext_count;

  logic                 satInReady;
  logic                 satOutValid;
  logic [DATA_W-1:0]    satOutData;
  logic [TAG_W-1:0]     satOutTag;
  logic                 satOutErr;
  logic [SAT_CNT_W-1:0] satCount;

  int testsRun    = 0;
  int testsFailed = 0;

  typedef struct {
    logic [MODE_W-1:0]  mode;
    logic [IMM_W-1:0]   imm;
    logic [SHAMT_W-1:0] shamt;
    logic [TAG_W-1:0]   tag;
    logic [DATA_W-1:0]  expData;
    logic               expErr;
    string              name;
  } vec_t;

  vec_t        vecs [NV];
  logic [15:0] streamImm [NSTREAM];
  logic [31:0] expStream;

  always #5 clk = ~clk;

  ext_pipe_stage #(
    .DATA_W(DATA_W), .IMM_W(IMM_W), .SHAMT_W(SHAMT_W), .TAG_W(TAG_W), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode),
    .in_imm(in_imm), .in_shamt(in_shamt), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_tag(out_tag), .out_err(out_err), .ext_count(ext_count)
  );

  ext_pipe_stage #(
    .DATA_W(DATA_W), .IMM_W(IMM_W), .SHAMT_W(SHAMT_W), .TAG_W(TAG_W), .CNT_W(SAT_CNT_W)
  ) satDut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(satInReady), .in_mode(in_mode),
    .in_imm(in_imm), .in_shamt(in_shamt), .in_tag(in_tag),
    .out_valid(satOutValid), .out_ready(out_ready), .out_data(satOutData),
    .out_tag(satOutTag), .out_err(satOutErr), .ext_count(satCount)
  );

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic valid, input logic [MODE_W-1:0] mode,
                               input logic [IMM_W-1:0] imm, input logic [SHAMT_W-1:0] shamt,
                               input logic [TAG_W-1:0] tag);
    in_valid = valid;
    in_mode  = mode;
    in_imm   = imm;
    in_shamt = shamt;
    in_tag   = tag;
  endtask

  // Leaves the caller at a falling edge with reset just released.
  task automatic doReset();
    @(negedge clk);
    rst_n     = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b0;
    applyStimulus(1'b0, EXT_SEXT, 16'h0, 5'h0, 5'h0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vecs[0] = '{EXT_SEXT, 16'h8000, 5'h1F, 5'd1, 32'hFFFF8000, 1'b0, "SEXT"};
    vecs[1] = '{EXT_ZEXT, 16'h8000, 5'h1F, 5'd2, 32'h00008000, 1'b0, "ZEXT"};
    vecs[2] = '{EXT_LUI,  16'h1234, 5'h1F, 5'd3, 32'h12340000, 1'b0, "LUI"};
    vecs[3] = '{EXT_SHZ,  16'hABCD, 5'h13, 5'd4, 32'h00000013, 1'b0, "SHZ"};
    vecs[4] = '{EXT_SHS,  16'hABCD, 5'h13, 5'd5, 32'hFFFFFFF3, 1'b0, "SHS"};
    vecs[5] = '{EXT_BOFF, 16'hFFFF, 5'h00, 5'd6, 32'hFFFFFFFC, 1'b0, "BOFF"};
    vecs[6] = '{3'd6,     16'hFFFF, 5'h1F, 5'd7, 32'h00000000, 1'b1, "MODE6"};
    vecs[7] = '{3'd7,     16'h1234, 5'h1F, 5'd8, 32'h00000000, 1'b1, "MODE7"};
    for (int i = 0; i < NSTREAM; i++) streamImm[i] = 16'($urandom);

    rst_n     = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b0;
    applyStimulus(1'b0, EXT_SEXT, 16'h0, 5'h0, 5'h0);

    // Reset state
    @(negedge clk);
    checkOutput("reset out_valid", 64'(out_valid), 64'd0);
    checkOutput("reset out_data", 64'(out_data), 64'd0);
    checkOutput("reset out_tag", 64'(out_tag), 64'd0);
    checkOutput("reset out_err", 64'(out_err), 64'd0);
    checkOutput("reset ext_count", 64'(ext_count), 64'd0);
    checkOutput("reset in_ready", 64'(in_ready), 64'd1);
    checkOutput("reset sat count", 64'(satCount), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Mode table, one beat per cycle, each result one cycle after accept
    out_ready = 1'b1;
    for (int i = 0; i <= NV; i++) begin
      if (i > 0) begin
        checkOutput({vecs[i-1].name, " data"}, 64'(out_data), 64'(vecs[i-1].expData));
        checkOutput({vecs[i-1].name, " valid/err/tag"}, 64'({out_valid, out_err, out_tag}),
                    64'({1'b1, vecs[i-1].expErr, vecs[i-1].tag}));
      end
      if (i < NV) applyStimulus(1'b1, vecs[i].mode, vecs[i].imm, vecs[i].shamt, vecs[i].tag);
      else        applyStimulus(1'b0, EXT_SEXT, 16'h0, 5'h0, 5'h0);
      @(negedge clk);
    end
    checkOutput("table drained out_valid", 64'(out_valid), 64'd0);
    checkOutput("table ext_count", 64'(ext_count), 64'(NV));

    // Backpressure: tags 1,2 accepted, tag 3 held until out_ready rises
    doReset();
    out_ready = 1'b0;
    applyStimulus(1'b1, EXT_ZEXT, 16'h0111, 5'h0, 5'd1);
    @(negedge clk);
    checkOutput("bp in_ready after tag1", 64'(in_ready), 64'd1);
    checkOutput("bp head tag1", 64'({out_valid, out_tag}), 64'({1'b1, 5'd1}));
    applyStimulus(1'b1, EXT_ZEXT, 16'h0222, 5'h0, 5'd2);
    @(negedge clk);
    checkOutput("bp in_ready after tag2", 64'(in_ready), 64'd0);
    checkOutput("bp head still tag1", 64'({out_valid, out_tag}), 64'({1'b1, 5'd1}));
    applyStimulus(1'b1, EXT_ZEXT, 16'h0333, 5'h0, 5'd3);
    @(negedge clk);
    checkOutput("bp tag3 held", 64'({in_ready, out_tag}), 64'({1'b0, 5'd1}));
    checkOutput("bp data tag1", 64'(out_data), 64'h111);
    out_ready = 1'b1;
    @(negedge clk);
    checkOutput("bp out tag2", 64'({out_valid, out_tag, out_data}), 64'({1'b1, 5'd2, 32'h222}));
    checkOutput("bp in_ready reopened", 64'(in_ready), 64'd1);
    @(negedge clk);
    checkOutput("bp out tag3", 64'({out_valid, out_tag, out_data}), 64'({1'b1, 5'd3, 32'h333}));
    applyStimulus(1'b0, EXT_SEXT, 16'h0, 5'h0, 5'h0);
    @(negedge clk);
    checkOutput("bp drained", 64'(out_valid), 64'd0);
    checkOutput("bp ext_count", 64'(ext_count), 64'd3);

    // Flush with both entries full and a beat on the input
    doReset();
    out_ready = 1'b0;
    applyStimulus(1'b1, EXT_ZEXT, 16'h0001, 5'h0, 5'd1);
    @(negedge clk);
    applyStimulus(1'b1, EXT_ZEXT, 16'h0002, 5'h0, 5'd2);
    @(negedge clk);
    checkOutput("flush pre both full", 64'({out_valid, in_ready}), 64'({1'b1, 1'b0}));
    applyStimulus(1'b1, EXT_ZEXT, 16'h0009, 5'h0, 5'd9);
    flush     = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    applyStimulus(1'b0, EXT_SEXT, 16'h0, 5'h0, 5'h0);
    checkOutput("flush out_valid", 64'(out_valid), 64'd0);
    checkOutput("flush in_ready", 64'(in_ready), 64'd1);
    checkOutput("flush ext_count", 64'(ext_count), 64'd0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checkOutput("flush no ghost beat", 64'(out_valid), 64'd0);
    end
    applyStimulus(1'b1, EXT_ZEXT, 16'h0005, 5'h0, 5'd5);
    @(negedge clk);
    applyStimulus(1'b0, EXT_SEXT, 16'h0, 5'h0, 5'h0);
    checkOutput("flush post beat", 64'({out_valid, out_tag, out_data}), 64'({1'b1, 5'd5, 32'h5}));
    @(negedge clk);
    checkOutput("flush post count", 64'(ext_count), 64'd1);

    // Streaming 100 beats at full rate
    doReset();
    out_ready = 1'b1;
    for (int i = 0; i <= NSTREAM; i++) begin
      if (i > 0) begin
        expStream = {{16{streamImm[i-1][15]}}, streamImm[i-1]};
        checkOutput($sformatf("stream beat %0d", i-1), 64'({out_valid, out_tag, out_data}),
                    64'({1'b1, 5'((i-1) % 32), expStream}));
      end
      if (i < NSTREAM) applyStimulus(1'b1, EXT_SEXT, streamImm[i], 5'h0, 5'(i % 32));
      else             applyStimulus(1'b0, EXT_SEXT, 16'h0, 5'h0, 5'h0);
      @(negedge clk);
    end
    checkOutput("stream drained", 64'(out_valid), 64'd0);
    checkOutput("stream ext_count", 64'(ext_count), 64'd100);

    // Asynchronous reset while two beats are held
    out_ready = 1'b0;
    applyStimulus(1'b1, EXT_ZEXT, 16'h001A, 5'h0, 5'h1A);
    @(negedge clk);
    applyStimulus(1'b1, EXT_ZEXT, 16'h001B, 5'h0, 5'h1B);
    @(negedge clk);
    checkOutput("rst pre held", 64'({out_valid, in_ready, out_tag}), 64'({1'b1, 1'b0, 5'h1A}));
    applyStimulus(1'b1, EXT_ZEXT, 16'h001C, 5'h0, 5'h1C);
    rst_n = 1'b0;
    #1;
    checkOutput("rst async out_valid", 64'(out_valid), 64'd0);
    checkOutput("rst async ext_count", 64'(ext_count), 64'd0);
    checkOutput("rst async in_ready", 64'(in_ready), 64'd1);
    #3;
    rst_n = 1'b1;
    applyStimulus(1'b0, EXT_SEXT, 16'h0, 5'h0, 5'h0);
    @(negedge clk);
    checkOutput("rst after release", 64'({out_valid, in_ready}), 64'({1'b0, 1'b1}));
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checkOutput("rst no old beat", 64'(out_valid), 64'd0);
    end
    checkOutput("rst count stays 0", 64'(ext_count), 64'd0);

    // Saturation on the 4-bit counter instance
    doReset();
    out_ready = 1'b1;
    for (int j = 0; j <= 22; j++) begin
      if (j == 15) checkOutput("sat count 14", 64'(satCount), 64'hE);
      if (j == 16) checkOutput("sat count 15", 64'(satCount), 64'hF);
      if (j == 17) checkOutput("sat no wrap", 64'(satCount), 64'hF);
      if (j < 20) applyStimulus(1'b1, EXT_ZEXT, 16'(j), 5'h0, 5'(j));
      else        applyStimulus(1'b0, EXT_SEXT, 16'h0, 5'h0, 5'h0);
      @(negedge clk);
    end
    checkOutput("sat final count", 64'(satCount), 64'hF);
    checkOutput("sat wide count", 64'(ext_count), 64'd20);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
